// File: rtl/ifm_sparse_packer_if.sv
// Stream-in / packed-write-out bundle for the IFM sparse packer.
// Handshake: an element moves when in_valid_i && in_ready_o are both high
// on a rising clock edge. in_valid_i never waits on in_ready_o, and
// in_ready_o depends only on packer state. The write side has no
// backpressure. Every strobe is a single-cycle pulse.
interface ifm_sparse_packer_if #(
  parameter int MEM_SIZE        = 128,
  parameter int PREFIX_SUM_SIZE = 32,
  parameter int DATA_WIDTH      = 8
);
  localparam int SM_NUM = MEM_SIZE / PREFIX_SUM_SIZE;
  localparam int AW     = $clog2(MEM_SIZE);
  localparam int SW     = (SM_NUM > 1) ? $clog2(SM_NUM) : 1;

  logic                       chunk_start_i;
  logic                       in_valid_i;
  logic                       in_ready_o;
  logic [DATA_WIDTH-1:0]      in_data_i;
  logic                       in_last_i;
  logic                       wr_en_o;
  logic [AW-1:0]              wr_addr_o;
  logic [DATA_WIDTH-1:0]      wr_data_o;
  logic                       sm_wr_en_o;
  logic [SW-1:0]              sm_wr_addr_o;
  logic [PREFIX_SUM_SIZE-1:0] sm_wr_data_o;
  logic                       done_o;
  logic [SW-1:0]              sm_last_o;
  logic [AW:0]                nz_count_o;

  modport slave (
    input  chunk_start_i, in_valid_i, in_data_i, in_last_i,
    output in_ready_o, wr_en_o, wr_addr_o, wr_data_o,
           sm_wr_en_o, sm_wr_addr_o, sm_wr_data_o,
           done_o, sm_last_o, nz_count_o
  );

  modport master (
    output chunk_start_i, in_valid_i, in_data_i, in_last_i,
    input  in_ready_o, wr_en_o, wr_addr_o, wr_data_o,
           sm_wr_en_o, sm_wr_addr_o, sm_wr_data_o,
           done_o, sm_last_o, nz_count_o
  );
endinterface

// File: rtl/ifm_sparse_packer.sv
// IFM sparse packer: turns a dense chunk stream into a sparsemap word per
// segment plus contiguously packed nonzero elements starting at address 0.
// PREFIX_SUM_SIZE must be at least 2.
module ifm_sparse_packer #(
  parameter int MEM_SIZE        = 128,
  parameter int PREFIX_SUM_SIZE = 32,
  parameter int DATA_WIDTH      = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ifm_sparse_packer_if.slave  bus,
  output logic                dbg_state_o
);
  localparam int SM_NUM = MEM_SIZE / PREFIX_SUM_SIZE;
  localparam int AW     = $clog2(MEM_SIZE);
  localparam int SW     = (SM_NUM > 1) ? $clog2(SM_NUM) : 1;
  localparam int PW     = $clog2(PREFIX_SUM_SIZE);

  typedef enum logic {S_IDLE = 1'b0, S_PACK = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [AW:0]                elem_cnt_q, nz_cnt_q;
  logic [SW-1:0]              seg_cnt_q;
  logic [PREFIX_SUM_SIZE-1:0] sm_acc_q;

  logic                       accept, elem_nz, elem_last, seg_close;
  logic [PW-1:0]              pos;
  logic [PREFIX_SUM_SIZE-1:0] sm_word;

  // Accept decode and the sparsemap word including the current element.
  // An element arriving together with chunk_start_i is dropped. Bits above
  // pos are already zero because sm_acc is cleared at every segment start.
  always_comb begin
    accept    = bus.in_valid_i && (state_q == S_PACK) && !bus.chunk_start_i;
    pos       = elem_cnt_q[PW-1:0];
    elem_nz   = |bus.in_data_i;
    elem_last = bus.in_last_i || (elem_cnt_q == (AW+1)'(MEM_SIZE - 1));
    seg_close = (pos == PW'(PREFIX_SUM_SIZE - 1)) || elem_last;
    sm_word   = sm_acc_q | ({{(PREFIX_SUM_SIZE-1){1'b0}}, elem_nz} << pos);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state: a start always enters or restarts PACK; the last element returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.chunk_start_i) state_d = S_PACK;
      S_PACK: begin
        if (bus.chunk_start_i)         state_d = S_PACK;
        else if (accept && elem_last)  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    bus.in_ready_o = (state_q == S_PACK);
    dbg_state_o    = state_q;
  end

  // Counters, sparsemap accumulator and registered write/report outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      elem_cnt_q       <= '0;
      nz_cnt_q         <= '0;
      seg_cnt_q        <= '0;
      sm_acc_q         <= '0;
      bus.wr_en_o      <= 1'b0;
      bus.wr_addr_o    <= '0;
      bus.wr_data_o    <= '0;
      bus.sm_wr_en_o   <= 1'b0;
      bus.sm_wr_addr_o <= '0;
      bus.sm_wr_data_o <= '0;
      bus.done_o       <= 1'b0;
      bus.sm_last_o    <= '0;
      bus.nz_count_o   <= '0;
    end else begin
      bus.wr_en_o    <= 1'b0;
      bus.sm_wr_en_o <= 1'b0;
      bus.done_o     <= 1'b0;
      if (bus.chunk_start_i) begin
        elem_cnt_q <= '0;
        nz_cnt_q   <= '0;
        seg_cnt_q  <= '0;
        sm_acc_q   <= '0;
      end else if (accept) begin
        elem_cnt_q <= elem_cnt_q + 1'b1;
        if (elem_nz) begin
          bus.wr_en_o   <= 1'b1;
          bus.wr_addr_o <= nz_cnt_q[AW-1:0];
          bus.wr_data_o <= bus.in_data_i;
          nz_cnt_q      <= nz_cnt_q + 1'b1;
        end
        if (seg_close) begin
          bus.sm_wr_en_o   <= 1'b1;
          bus.sm_wr_addr_o <= seg_cnt_q;
          bus.sm_wr_data_o <= sm_word;
          seg_cnt_q        <= seg_cnt_q + 1'b1;
          sm_acc_q         <= '0;
        end else begin
          sm_acc_q <= sm_word;
        end
        if (elem_last) begin
          bus.done_o     <= 1'b1;
          bus.sm_last_o  <= seg_cnt_q;
          bus.nz_count_o <= nz_cnt_q + (AW+1)'(elem_nz);
        end
      end
    end
  end
endmodule

// File: tb/tb_ifm_sparse_packer.sv
// Bench for ifm_sparse_packer: directed chunks plus random chunks, with an
// expected-write model built from the chunk contents.
module tb_ifm_sparse_packer;
  localparam int MEM = 128;
  localparam int PSS = 32;
  localparam int DW  = 8;
  localparam int AW  = 7;
  localparam int SW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;

  ifm_sparse_packer_if #(.MEM_SIZE(MEM), .PREFIX_SUM_SIZE(PSS), .DATA_WIDTH(DW)) bus();

  ifm_sparse_packer #(.MEM_SIZE(MEM), .PREFIX_SUM_SIZE(PSS), .DATA_WIDTH(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard queues.
  logic [AW+DW-1:0] exp_d_q[$];
  logic [SW+PSS-1:0] exp_sm_q[$];
  logic [SW+AW:0]   exp_done_q[$];
  logic [DW-1:0]    chunk_d[$];
  logic [PSS-1:0]   last_sm_word = '0;

  logic [AW+DW-1:0] e_d;
  logic [SW+PSS-1:0] e_sm;
  logic [SW+AW:0]   e_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packed nonzero writes, per-segment sparsemap words and
  // the done report, computed from the first n entries of chunk_d.
  // full=0 models a chunk that is abandoned (data writes only).
  task automatic push_expect(input int n, input bit full);
    int nz = 0;
    int seg = 0;
    int last_seg = 0;
    logic [PSS-1:0] w = '0;
    for (int i = 0; i < n; i++) begin
      if (chunk_d[i] != 0) begin
        exp_d_q.push_back({AW'(nz), chunk_d[i]});
        nz++;
      end
      w[i % PSS] = (chunk_d[i] != 0);
      if (full && ((i % PSS) == PSS - 1 || i == n - 1)) begin
        exp_sm_q.push_back({SW'(seg), w});
        last_seg = seg;
        seg++;
        w = '0;
      end
    end
    if (full) exp_done_q.push_back({SW'(last_seg), (AW+1)'(nz)});
  endtask

  // Compare process: every strobe must match the head of its queue.
  always @(negedge clk) begin
    if (bus.wr_en_o === 1'b1) begin
      if (exp_d_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
      else begin
        e_d = exp_d_q.pop_front();
        check("wr_addr_data", {bus.wr_addr_o, bus.wr_data_o}, e_d);
      end
    end
    if (bus.sm_wr_en_o === 1'b1) begin
      last_sm_word = bus.sm_wr_data_o;
      if (exp_sm_q.size() == 0) check("sm_unexpected", 64'd1, 64'd0);
      else begin
        e_sm = exp_sm_q.pop_front();
        check("sm_addr_word", {bus.sm_wr_addr_o, bus.sm_wr_data_o}, e_sm);
      end
    end
    if (bus.done_o === 1'b1) begin
      if (exp_done_q.size() == 0) check("done_unexpected", 64'd1, 64'd0);
      else begin
        e_done = exp_done_q.pop_front();
        check("done_report", {bus.sm_last_o, bus.nz_count_o}, e_done);
      end
    end
  end

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input bit with_valid, input logic [DW-1:0] d);
    bus.chunk_start_i = 1'b1;
    bus.in_valid_i    = with_valid;
    bus.in_data_i     = d;
    bus.in_last_i     = 1'b0;
    step();
    bus.chunk_start_i = 1'b0;
    bus.in_valid_i    = 1'b0;
  endtask

  task automatic send_elems(input int n, input int bubble_pct, input bit use_last);
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < bubble_pct) begin
        bus.in_valid_i = 1'b0;
        step();
      end
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = chunk_d[i];
      bus.in_last_i  = use_last && (i == n - 1);
      if (bus.in_ready_o !== 1'b1) check("ready_in_pack", {63'd0, bus.in_ready_o}, 64'd1);
      step();
    end
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
  endtask

  task automatic fill_s1();
    chunk_d = {};
    for (int i = 0; i < 32; i++) chunk_d.push_back(8'h00);
    chunk_d[0]  = 8'h11;
    chunk_d[5]  = 8'h22;
    chunk_d[31] = 8'h33;
  endtask

  task automatic check_report(input string name, input int nz, input int sl, input logic [PSS-1:0] w);
    step();
    step();
    check({name, "_nz"}, 64'(bus.nz_count_o), 64'(nz));
    check({name, "_sm_last"}, 64'(bus.sm_last_o), 64'(sl));
    check({name, "_last_sm_word"}, 64'(last_sm_word), 64'(w));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, {63'd0, bus.in_ready_o}, 64'd0);
    check({name, "_strobes"}, {61'd0, bus.wr_en_o, bus.sm_wr_en_o, bus.done_o}, 64'd0);
    check({name, "_wr"}, {bus.wr_addr_o, bus.wr_data_o}, 64'd0);
    check({name, "_sm"}, {bus.sm_wr_addr_o, bus.sm_wr_data_o}, 64'd0);
    check({name, "_report"}, {bus.sm_last_o, bus.nz_count_o}, 64'd0);
    check({name, "_state"}, {63'd0, dbg_state}, 64'd0);
  endtask

  initial begin
    int len, zpct, bub, nz;
    bit ul;
    bus.chunk_start_i = 1'b0;
    bus.in_valid_i    = 1'b0;
    bus.in_data_i     = '0;
    bus.in_last_i     = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Scenario 1: three nonzeros in one full segment.
    fill_s1();
    push_expect(32, 1'b1);
    start_pulse(1'b0, '0);
    send_elems(32, 0, 1'b1);
    check("s1_ready_after_last", {63'd0, bus.in_ready_o}, 64'd0);
    check_report("s1", 3, 0, 32'h8000_0021);

    // Scenario 2: 40 nonzeros spanning two segments; a start with valid
    // high in IDLE must not accept that element.
    chunk_d = {};
    for (int i = 0; i < 40; i++) chunk_d.push_back(8'h01);
    push_expect(40, 1'b1);
    start_pulse(1'b1, 8'h01);
    send_elems(40, 0, 1'b1);
    check_report("s2", 40, 1, 32'h0000_00FF);

    // Scenario 3: full chunk of zeros, implicit last.
    chunk_d = {};
    for (int i = 0; i < MEM; i++) chunk_d.push_back(8'h00);
    push_expect(MEM, 1'b1);
    start_pulse(1'b0, '0);
    send_elems(MEM, 0, 1'b0);
    check("s3_ready_after_implicit_last", {63'd0, bus.in_ready_o}, 64'd0);
    check_report("s3", 0, 3, 32'h0);

    // Scenario 4: scenario 1 with valid bubbles.
    fill_s1();
    push_expect(32, 1'b1);
    start_pulse(1'b0, '0);
    send_elems(32, 40, 1'b1);
    check_report("s4", 3, 0, 32'h8000_0021);

    // Scenario 5: abort after 10 elements; the element under the restart is dropped.
    fill_s1();
    push_expect(10, 1'b0);
    start_pulse(1'b0, '0);
    send_elems(10, 0, 1'b0);
    start_pulse(1'b1, 8'h55);
    push_expect(32, 1'b1);
    send_elems(32, 0, 1'b1);
    check_report("s5", 3, 0, 32'h8000_0021);

    // Scenario 6: reset after 20 elements, then a fresh chunk.
    chunk_d = {};
    for (int i = 0; i < 20; i++) chunk_d.push_back(DW'($urandom_range(255)));
    push_expect(20, 1'b0);
    start_pulse(1'b0, '0);
    send_elems(20, 0, 1'b0);
    rst = 1'b1;
    step();
    check_reset_outputs("midreset");
    rst = 1'b0;
    step();
    fill_s1();
    push_expect(32, 1'b1);
    start_pulse(1'b0, '0);
    send_elems(32, 0, 1'b1);
    check_report("s6", 3, 0, 32'h8000_0021);

    // Random chunks.
    for (int c = 0; c < 10; c++) begin
      len  = $urandom_range(MEM, 1);
      zpct = $urandom_range(90);
      bub  = $urandom_range(30);
      ul   = (len < MEM) ? 1'b1 : 1'($urandom_range(1));
      chunk_d = {};
      nz = 0;
      for (int i = 0; i < len; i++) begin
        if (int'($urandom_range(99)) < zpct) chunk_d.push_back(8'h00);
        else begin
          chunk_d.push_back(DW'($urandom_range(255, 1)));
          nz++;
        end
      end
      push_expect(len, 1'b1);
      start_pulse(1'b0, '0);
      send_elems(len, bub, ul);
      check("rand_ready_after_last", {63'd0, bus.in_ready_o}, 64'd0);
      step();
      step();
      check("rand_nz", 64'(bus.nz_count_o), 64'(nz));
      check("rand_sm_last", 64'(bus.sm_last_o), 64'((len - 1) / PSS));
    end

    repeat (3) step();
    check("drain_wr", 64'(exp_d_q.size()), 64'd0);
    check("drain_sm", 64'(exp_sm_q.size()), 64'd0);
    check("drain_done", 64'(exp_done_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ifm_sparse_packer.md
# ifm_sparse_packer

Write-side counterpart of the IFM sparse read path: accepts a dense stream of IFM elements for one chunk, emits a sparsemap word per `PREFIX_SUM_SIZE` elements and writes only nonzero elements, packed contiguously from address 0, into the chunk data buffer. The layout it produces is exactly what the prefix-sum read-address logic expects: bit i of a sparsemap word is element i of that segment, and a segment's nonzeros directly follow the previous segment's. It also reports the last sparsemap index and the nonzero count to the chunk controller.

## Interface
- `MEM_SIZE`, 128: max elements per chunk; power of 2.
- `PREFIX_SUM_SIZE`, 32: elements per sparsemap word; power of 2; divides `MEM_SIZE`.
- `DATA_WIDTH`, 8: element width.
- Derived: `SM_NUM = MEM_SIZE/PREFIX_SUM_SIZE`; `AW = $clog2(MEM_SIZE)`; `SW = max(1,$clog2(SM_NUM))`.
- `clk_i` in 1: sole clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `chunk_start_i` in 1: begin new chunk (aborts any chunk in progress).
- `in_valid_i` in 1: element valid.
- `in_ready_o` out 1: element accepted when valid && ready.
- `in_data_i` in `DATA_WIDTH`: dense element.
- `in_last_i` in 1: final element of chunk.
- `wr_en_o` out 1: packed data write strobe.
- `wr_addr_o` out `AW`: packed data address.
- `wr_data_o` out `DATA_WIDTH`: nonzero element.
- `sm_wr_en_o` out 1: sparsemap write strobe.
- `sm_wr_addr_o` out `SW`: sparsemap word index.
- `sm_wr_data_o` out `PREFIX_SUM_SIZE`: sparsemap word.
- `done_o` out 1: one-cycle pulse, chunk packed.
- `sm_last_o` out `SW`: index of last sparsemap word written; held until next `done_o`.
- `nz_count_o` out `AW+1`: nonzeros in chunk; held until next `done_o`.

## Operation
- States IDLE, PACK. Reset -> IDLE.
- IDLE: `in_ready_o`=0. `chunk_start_i` -> PACK, clear elem_cnt (AW+1 bits), nz_cnt (AW+1), seg_cnt (SW), sm_acc.
- PACK: `in_ready_o`=1. On accept: pos = elem_cnt mod `PREFIX_SUM_SIZE`; sm_acc[pos] = (in_data_i != 0); elem_cnt++.
- Nonzero accept: data write with addr = nz_cnt, nz_cnt++. Zero accept: no data write.
- Segment close when pos == `PREFIX_SUM_SIZE`-1, or element is last: sparsemap write of sm_acc including current bit, positions above pos forced 0; addr = seg_cnt; seg_cnt++; sm_acc cleared.
- Chunk end when `in_last_i` accepted, or elem_cnt reaches `MEM_SIZE` (implicit last on element `MEM_SIZE`-1): -> IDLE, `done_o`, latch `sm_last_o` = closing seg index, `nz_count_o` = final nz count.
- `chunk_start_i` in PACK: restart (clear counters/sm_acc, stay PACK); partial segment discarded, no sm write, no `done_o`. If an element is accepted that same cycle it is dropped (no writes). Writes from prior accepts already registered still issue.
- `chunk_start_i` in IDLE same cycle as `in_valid_i`: not accepted (ready 0).
- nz_cnt max = `MEM_SIZE`; addresses never wrap within a chunk.

## Timing
- All outputs registered except `in_ready_o` (decoded from state only).
- Element accepted cycle t -> data write and/or sm write at t+1; `done_o` at t+1 together with the final writes; state IDLE and `in_ready_o`=0 at t+1.
- Throughput one element/cycle; `in_valid_i` bubbles allowed, no effect on output content.
- Reset values: all strobes 0, `in_ready_o`=0, all addr/data/`sm_last_o`/`nz_count_o` = 0. `rst_i` dominates `chunk_start_i`; mid-chunk reset drops state, next cycle all outputs at reset values.

## Test plan
- PSS=32, MEM=128: start; 32 elements, nonzero 0x11@0, 0x22@5, 0x33@31, last@31 -> writes (0,0x11),(1,0x22),(2,0x33); sm addr 0 = 0x80000021; done, nz 3, sm_last 0.
- 40 elements all 0x01, last@39 -> data addr 0..39; sm addr0 0xFFFFFFFF, addr1 0x000000FF; nz 40, sm_last 1.
- 128 zero elements, no last -> 4 sm writes of 0 at addr 0..3, no data writes, done after 128th, nz 0, sm_last 3, ready low next cycle.
- Scenario 1 with random valid bubbles -> identical write sequence and done values.
- 10 elements then `chunk_start_i` -> no sm write/done; next chunk as scenario 1 writes from addr 0, identical results.
- `rst_i` after 20 elements -> next cycle all outputs reset values, IDLE; subsequent chunk_start behaves as fresh.
